// File: rtl/cardio_mlp_feeder_if.sv
// rtl/cardio_mlp_feeder_if.sv - feature-in and result-out handshake bundle for the cardio MLP feeder
interface cardio_mlp_feeder_if #(
    parameter int FEAT_W = 4,
    parameter int OUT_W  = 22
) ();
    logic              feat_valid;
    logic [FEAT_W-1:0] feat_data;
    logic              feat_last;
    logic              feat_ready;
    logic              res_valid;
    logic [OUT_W-1:0]  res_data;
    logic              res_ready;
    logic              frame_err;

    // master: feature source plus result consumer; slave: the feeder itself
    modport master (
        output feat_valid, feat_data, feat_last, res_ready,
        input  feat_ready, res_valid, res_data, frame_err
    );

    modport slave (
        input  feat_valid, feat_data, feat_last, res_ready,
        output feat_ready, res_valid, res_data, frame_err
    );
endinterface

// File: rtl/cardio_mlp_feeder.sv
// rtl/cardio_mlp_feeder.sv - assembles 21 features into the regressor vector and returns its settled output
// Optional framing check on feat_last enabled by FEEDER_LAST_CHECK_EN.
module cardio_mlp_feeder #(
    parameter int NUM_FEAT   = 21,
    parameter int FEAT_W     = 4,
    parameter int OUT_W      = 22,
    parameter int SETTLE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    cardio_mlp_feeder_if.slave         bus,
    output logic [NUM_FEAT*FEAT_W-1:0] vec,
    input  logic [OUT_W-1:0]           res_in
);
    localparam int IDX_W = $clog2(NUM_FEAT);
    localparam int CNT_W = $clog2(SETTLE_CYC) + 1;
    localparam int VEC_W = NUM_FEAT * FEAT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [VEC_W-1:0] vec_q;
    logic [OUT_W-1:0] res_data_q;
    logic             res_valid_q;

    logic feat_ready;
    logic accept;
    logic is_last;
    logic frame_bad;

    // ready is held low while reset is asserted even though the state already reads LOAD
    assign feat_ready = (state_q == LOAD) && !rst;
    assign accept     = bus.feat_valid && feat_ready;
    assign is_last    = (idx_q == LAST_IDX);

`ifdef FEEDER_LAST_CHECK_EN
    logic frame_err_q;

    assign frame_bad = (bus.feat_last != is_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= accept && frame_bad;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    logic unused_last;

    assign frame_bad     = 1'b0;
    assign unused_last   = bus.feat_last;
    assign bus.frame_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (accept && is_last && !frame_bad) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            vec_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (frame_bad) begin
                            // a mis-framed feature is dropped along with the partial frame
                            vec_q <= '0;
                            idx_q <= '0;
                        end else begin
                            vec_q[idx_q*FEAT_W +: FEAT_W] <= bus.feat_data;
                            if (is_last) begin
                                idx_q <= '0;
                                cnt_q <= CNT_INIT;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        res_data_q  <= res_in;
                        res_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESULT: begin
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        vec_q       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.feat_ready = feat_ready;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign vec            = vec_q;
endmodule

// File: tb/tb_cardio_mlp_feeder.sv
// tb/tb_cardio_mlp_feeder.sv - randomized self-checking bench for cardio_mlp_feeder with a stand-in regressor
module tb_cardio_mlp_feeder;
    localparam int NF     = 21;
    localparam int FW     = 4;
    localparam int OW     = 22;
    localparam int SETTLE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF*FW-1:0] vec;
    logic [OW-1:0] res_in;

    cardio_mlp_feeder_if #(.FEAT_W(FW), .OUT_W(OW)) bus ();

    cardio_mlp_feeder #(.NUM_FEAT(NF), .FEAT_W(FW), .OUT_W(OW), .SETTLE_CYC(SETTLE)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .vec    (vec),
        .res_in (res_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int rr_mode  = 0;

    // stand-in regressor: position-weighted sum, yields 0xFC74 for the all-zero vector
    function automatic logic [OW-1:0] regress(input logic [NF*FW-1:0] v);
        logic [OW-1:0] acc;
        acc = '0;
        for (int k = 0; k < NF; k++) begin
            acc = acc + OW'(v[k*FW +: FW]) * OW'(k * 2731 + 97);
        end
        return acc ^ 22'h00FC74;
    endfunction

    assign res_in = regress(vec);

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // model: frame contents as an array, result as a delayed function of the completed frame
    logic [FW-1:0] m_feat [NF];
    int            m_cnt     = 0;
    bit            m_ready   = 1'b1;
    int            m_wait    = 0;
    bit            m_rv      = 1'b0;
    logic [OW-1:0] m_rd      = '0;
    bit            m_err     = 1'b0;
    int            m_results = 0;
    int            dut_hs    = 0;

    function automatic logic [NF*FW-1:0] m_pack();
        logic [NF*FW-1:0] v;
        for (int k = 0; k < NF; k++) v[k*FW +: FW] = m_feat[k];
        return v;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < NF; k++) m_feat[k] = '0;
        m_cnt = 0;
    endtask

    initial m_clear();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clear();
            m_ready = 1'b1;
            m_wait  = 0;
            m_rv    = 1'b0;
            m_rd    = '0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_ready) begin
                if (bus.feat_valid) begin
`ifdef FEEDER_LAST_CHECK_EN
                    if (bus.feat_last != (m_cnt == NF - 1)) begin
                        m_clear();
                        m_err = 1'b1;
                    end else
`endif
                    begin
                        m_feat[m_cnt] = bus.feat_data;
                        m_cnt++;
                        if (m_cnt == NF) begin
                            m_ready = 1'b0;
                            m_wait  = SETTLE;
                        end
                    end
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_rv = 1'b1;
                    m_rd = regress(m_pack());
                end
            end else if (m_rv && bus.res_ready) begin
                m_rv    = 1'b0;
                m_ready = 1'b1;
                m_results++;
                m_clear();
            end
        end
    end

    always @(negedge clk) begin
        check("feat_ready", 128'(bus.feat_ready), 128'(m_ready && !rst));
        check("res_valid", 128'(bus.res_valid), 128'(m_rv));
        check("vec", 128'(vec), 128'(m_pack()));
        check("frame_err", 128'(bus.frame_err), 128'(m_err));
        if (m_rv) check("res_data", 128'(bus.res_data), 128'(m_rd));
        if (bus.res_valid && bus.res_ready && !rst) dut_hs++;
    end

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       bus.res_ready = 1'b1;
            1:       bus.res_ready = 1'($urandom_range(1));
            default: bus.res_ready = 1'b0;
        endcase
    end

    task automatic send_feat(input logic [FW-1:0] d, input logic last, input int gap);
        int  t;
        logic r;
        while (int'($urandom_range(99)) < gap) begin
            bus.feat_valid = 1'b0;
            bus.feat_data  = FW'($urandom);
            @(posedge clk); #1;
        end
        bus.feat_valid = 1'b1;
        bus.feat_data  = d;
        bus.feat_last  = last;
        t = 0;
        forever begin
            @(negedge clk);
            r = bus.feat_ready;
            @(posedge clk); #1;
            if (r) break;
            t++;
            if (t > 400) begin
                timeout("feat_accept");
                break;
            end
        end
        bus.feat_valid = 1'b0;
        bus.feat_last  = 1'b0;
        bus.feat_data  = FW'($urandom);
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.res_valid) break;
            if (lat > 400) begin
                timeout("res_valid_wait");
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (!bus.res_valid && bus.feat_ready) break;
            t++;
            if (t > 400) begin
                timeout("idle_wait");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        bus.feat_valid = 1'b0;
        bus.feat_data  = '0;
        bus.feat_last  = 1'b0;
        bus.res_ready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_feat_ready", 128'(bus.feat_ready), 128'(0));
        check("rst_res_valid", 128'(bus.res_valid), 128'(0));
        check("rst_vec", 128'(vec), 128'(0));
        check("rst_res_data", 128'(bus.res_data), 128'(0));
        check("rst_frame_err", 128'(bus.frame_err), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        rr_mode = 0;
        for (int k = 0; k < NF; k++) send_feat('0, k == NF - 1, 0);
        wait_res(lat);
        check("settle_latency", 128'(lat), 128'(SETTLE + 1));
        check("zero_res_data", 128'(bus.res_data), 128'(22'd64628));
        wait_idle();

        rr_mode = 2;
        for (int k = 0; k < NF; k++) send_feat(FW'(k % 16), k == NF - 1, 0);
        wait_res(lat);
        check("pat_slot0", 128'(vec[3:0]), 128'(0));
        check("pat_slot1", 128'(vec[7:4]), 128'(1));
        check("pat_slot15", 128'(vec[63:60]), 128'(15));
        check("pat_slot20", 128'(vec[83:80]), 128'(4));
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            bus.feat_valid = 1'($urandom_range(1));
            bus.feat_data  = FW'($urandom);
            bus.feat_last  = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        bus.feat_valid = 1'b0;
        bus.feat_last  = 1'b0;
        rr_mode = 0;
        wait_idle();

        for (int k = 0; k < 10; k++) send_feat(FW'($urandom), 1'b0, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_vec", 128'(vec), 128'(0));
        check("mid_rst_res_valid", 128'(bus.res_valid), 128'(0));
        check("mid_rst_res_data", 128'(bus.res_data), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < NF; k++) send_feat(FW'($urandom), k == NF - 1, 30);
        wait_res(lat);
        wait_idle();

`ifdef FEEDER_LAST_CHECK_EN
        for (int k = 0; k < 6; k++) send_feat(FW'($urandom), k == 5, 0);
`else
        for (int k = 0; k < NF; k++) send_feat(FW'($urandom), k == 5, 0);
        wait_res(lat);
        wait_idle();
`endif
        for (int k = 0; k < NF; k++) send_feat(FW'($urandom), k == NF - 1, 0);
        wait_res(lat);
        wait_idle();

        rr_mode = 1;
        for (int f = 0; f < 1000; f++) begin
            for (int k = 0; k < NF; k++) send_feat(FW'($urandom), k == NF - 1, 50);
        end
        wait_res(lat);
        rr_mode = 0;
        wait_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("result_count", 128'(dut_hs), 128'(m_results));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
